// File: rtl/fu_exec_cluster.sv
// fu_exec_cluster: NUM_ALU single-cycle ALU lanes plus one pipelined multiplier.
// Each lane/stage holds one completed result; a round-robin arbiter drains up to
// CDB_W results per cycle onto the completion ports.
module fu_exec_cluster #(
    parameter int XLEN        = 32,
    parameter int NUM_ALU     = 3,
    parameter int TAG_W       = 6,
    parameter int MULT_STAGES = 4,
    parameter int CDB_W       = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [NUM_ALU-1:0]       alu_valid,
    input  logic [NUM_ALU*XLEN-1:0]  alu_opa,
    input  logic [NUM_ALU*XLEN-1:0]  alu_opb,
    input  logic [NUM_ALU*5-1:0]     alu_func,
    input  logic [NUM_ALU*TAG_W-1:0] alu_tag,
    output logic [NUM_ALU-1:0]       alu_ready,
    input  logic                     mult_valid,
    input  logic [XLEN-1:0]          mult_mcand,
    input  logic [XLEN-1:0]          mult_mplier,
    input  logic [1:0]               mult_func,
    input  logic [TAG_W-1:0]         mult_tag,
    output logic                     mult_ready,
    output logic [CDB_W-1:0]         cdb_valid,
    output logic [CDB_W*TAG_W-1:0]   cdb_tag,
    output logic [CDB_W*XLEN-1:0]    cdb_value,
    output logic                     busy
);

    localparam int NSRC  = NUM_ALU + 1;
    localparam int PTR_W = $clog2(NSRC);
    localparam int SH_W  = $clog2(XLEN);

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_SLT  = 5'd5;
    localparam logic [4:0] ALU_SLTU = 5'd6;
    localparam logic [4:0] ALU_SLL  = 5'd7;
    localparam logic [4:0] ALU_SRL  = 5'd8;
    localparam logic [4:0] ALU_SRA  = 5'd9;

    logic [NUM_ALU-1:0]     lane_valid;
    logic [TAG_W-1:0]       lane_tag   [NUM_ALU];
    logic [XLEN-1:0]        lane_value [NUM_ALU];
    logic [XLEN-1:0]        alu_result [NUM_ALU];
    logic [NUM_ALU-1:0]     alu_fire;

    logic [MULT_STAGES-1:0] mst_valid;
    logic [TAG_W-1:0]       mst_tag   [MULT_STAGES];
    logic [XLEN-1:0]        mst_value [MULT_STAGES];
    logic                   mult_advance;
    logic                   mult_fire;
    logic                   mcand_signed;
    logic                   mplier_signed;
    logic [2*XLEN-1:0]      mcand_ext;
    logic [2*XLEN-1:0]      mplier_ext;
    logic [2*XLEN-1:0]      product;
    logic [XLEN-1:0]        mult_result;

    logic [NSRC-1:0]        src_valid;
    logic [TAG_W-1:0]       src_tag   [NSRC];
    logic [XLEN-1:0]        src_value [NSRC];
    logic [NSRC-1:0]        grant;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       rr_next;
    int                     n_grant;
    int                     src_idx;

    function automatic logic [XLEN-1:0] alu_compute(input logic [4:0]      func,
                                                    input logic [XLEN-1:0] a,
                                                    input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        logic [SH_W-1:0] sh;
        sh = b[SH_W-1:0];
        case (func)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_SLT:  r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: r = {{(XLEN-1){1'b0}}, a < b};
            ALU_SLL:  r = a << sh;
            ALU_SRL:  r = a >> sh;
            ALU_SRA:  r = $unsigned($signed(a) >>> sh);
            default:  r = '0;
        endcase
        return r;
    endfunction

    // Per-lane combinational ALU results, captured into the lane buffer on fire
    always_comb begin
        for (int i = 0; i < NUM_ALU; i++)
            alu_result[i] = alu_compute(alu_func[i*5 +: 5], alu_opa[i*XLEN +: XLEN],
                                        alu_opb[i*XLEN +: XLEN]);
    end

    // A lane accepts when its buffer is empty or is being drained this cycle
    always_comb begin
        for (int i = 0; i < NUM_ALU; i++)
            alu_ready[i] = reset && !flush && (!lane_valid[i] || grant[i]);
        alu_fire = alu_valid & alu_ready;
    end

    assign mult_advance = !mst_valid[MULT_STAGES-1] || grant[NUM_ALU];
    assign mult_ready   = reset && !flush && mult_advance;
    assign mult_fire    = mult_valid && mult_ready;
    assign busy         = (|lane_valid) || (|mst_valid);

    // Sign-extend each operand to 2*XLEN so one unsigned multiply covers all four flavours
    always_comb begin
        mcand_signed  = (mult_func == 2'b01) || (mult_func == 2'b10);
        mplier_signed = (mult_func == 2'b01);
        mcand_ext     = {{XLEN{mcand_signed & mult_mcand[XLEN-1]}}, mult_mcand};
        mplier_ext    = {{XLEN{mplier_signed & mult_mplier[XLEN-1]}}, mult_mplier};
        product       = mcand_ext * mplier_ext;
        mult_result   = (mult_func == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    end

    // Gather arbitration sources: ALU buffers first, multiplier final stage last
    always_comb begin
        for (int i = 0; i < NUM_ALU; i++) begin
            src_valid[i] = lane_valid[i];
            src_tag[i]   = lane_tag[i];
            src_value[i] = lane_value[i];
        end
        src_valid[NUM_ALU] = mst_valid[MULT_STAGES-1];
        src_tag[NUM_ALU]   = mst_tag[MULT_STAGES-1];
        src_value[NUM_ALU] = mst_value[MULT_STAGES-1];
    end

    // Round-robin scan from rr_ptr; k-th granted source drives completion port k
    always_comb begin
        grant     = '0;
        cdb_valid = '0;
        cdb_tag   = '0;
        cdb_value = '0;
        rr_next   = rr_ptr;
        n_grant   = 0;
        src_idx   = 0;
        for (int j = 0; j < NSRC; j++) begin
            src_idx = int'(rr_ptr) + j;
            if (src_idx >= NSRC)
                src_idx = src_idx - NSRC;
            if (!flush && src_valid[src_idx] && (n_grant < CDB_W)) begin
                grant[src_idx]                     = 1'b1;
                cdb_valid[n_grant]                 = 1'b1;
                cdb_tag[n_grant*TAG_W +: TAG_W]    = src_tag[src_idx];
                cdb_value[n_grant*XLEN +: XLEN]    = src_value[src_idx];
                rr_next                            = PTR_W'((src_idx + 1) % NSRC);
                n_grant                            = n_grant + 1;
            end
        end
    end

    // Lane buffers: refill wins over drain so same-cycle drain+refill keeps the new result
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lane_valid <= '0;
            for (int i = 0; i < NUM_ALU; i++) begin
                lane_tag[i]   <= '0;
                lane_value[i] <= '0;
            end
        end else if (flush) begin
            lane_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_ALU; i++) begin
                if (alu_fire[i]) begin
                    lane_valid[i] <= 1'b1;
                    lane_tag[i]   <= alu_tag[i*TAG_W +: TAG_W];
                    lane_value[i] <= alu_result[i];
                end else if (grant[i]) begin
                    lane_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Multiplier pipe shifts as a whole only when the final stage can move on
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mst_valid <= '0;
            for (int s = 0; s < MULT_STAGES; s++) begin
                mst_tag[s]   <= '0;
                mst_value[s] <= '0;
            end
        end else if (flush) begin
            mst_valid <= '0;
        end else if (mult_advance) begin
            mst_valid[0] <= mult_fire;
            mst_tag[0]   <= mult_tag;
            mst_value[0] <= mult_result;
            for (int s = 1; s < MULT_STAGES; s++) begin
                mst_valid[s] <= mst_valid[s-1];
                mst_tag[s]   <= mst_tag[s-1];
                mst_value[s] <= mst_value[s-1];
            end
        end
    end

    // Round-robin pointer moves past the last granted source; flush leaves it alone
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            rr_ptr <= '0;
        else
            rr_ptr <= rr_next;
    end

endmodule

// File: tb/tb_fu_exec_cluster.sv
// tb_fu_exec_cluster: directed scenarios for the execute cluster with hand-computed results.
module tb_fu_exec_cluster;

    localparam int XLEN        = 32;
    localparam int NUM_ALU     = 3;
    localparam int TAG_W       = 6;
    localparam int MULT_STAGES = 4;
    localparam int CDB_W       = 2;

    localparam logic [4:0] F_ADD = 5'd0;
    localparam logic [4:0] F_SUB = 5'd1;
    localparam logic [4:0] F_AND = 5'd2;
    localparam logic [4:0] F_OR  = 5'd3;
    localparam logic [4:0] F_XOR = 5'd4;
    localparam logic [4:0] F_SRA = 5'd9;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     flush;
    logic [NUM_ALU-1:0]       alu_valid;
    logic [NUM_ALU*XLEN-1:0]  alu_opa;
    logic [NUM_ALU*XLEN-1:0]  alu_opb;
    logic [NUM_ALU*5-1:0]     alu_func;
    logic [NUM_ALU*TAG_W-1:0] alu_tag;
    logic [NUM_ALU-1:0]       alu_ready;
    logic                     mult_valid;
    logic [XLEN-1:0]          mult_mcand;
    logic [XLEN-1:0]          mult_mplier;
    logic [1:0]               mult_func;
    logic [TAG_W-1:0]         mult_tag;
    logic                     mult_ready;
    logic [CDB_W-1:0]         cdb_valid;
    logic [CDB_W*TAG_W-1:0]   cdb_tag;
    logic [CDB_W*XLEN-1:0]    cdb_value;
    logic                     busy;

    int vectors     = 0;
    int miscompares = 0;

    fu_exec_cluster #(
        .XLEN(XLEN), .NUM_ALU(NUM_ALU), .TAG_W(TAG_W),
        .MULT_STAGES(MULT_STAGES), .CDB_W(CDB_W)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .alu_valid(alu_valid), .alu_opa(alu_opa), .alu_opb(alu_opb),
        .alu_func(alu_func), .alu_tag(alu_tag), .alu_ready(alu_ready),
        .mult_valid(mult_valid), .mult_mcand(mult_mcand), .mult_mplier(mult_mplier),
        .mult_func(mult_func), .mult_tag(mult_tag), .mult_ready(mult_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [TAG_W-1:0] port_tag(input int k);
        return cdb_tag[k*TAG_W +: TAG_W];
    endfunction

    function automatic logic [XLEN-1:0] port_value(input int k);
        return cdb_value[k*XLEN +: XLEN];
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs;
        flush       = 1'b0;
        alu_valid   = '0;
        alu_opa     = '0;
        alu_opb     = '0;
        alu_func    = '0;
        alu_tag     = '0;
        mult_valid  = 1'b0;
        mult_mcand  = '0;
        mult_mplier = '0;
        mult_func   = '0;
        mult_tag    = '0;
    endtask

    task automatic drive_alu(input int lane, input logic [4:0] func, input logic [XLEN-1:0] a,
                             input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
        alu_valid[lane]               = 1'b1;
        alu_func[lane*5 +: 5]         = func;
        alu_opa[lane*XLEN +: XLEN]    = a;
        alu_opb[lane*XLEN +: XLEN]    = b;
        alu_tag[lane*TAG_W +: TAG_W]  = tag;
    endtask

    task automatic drive_mult(input logic [1:0] func, input logic [XLEN-1:0] a,
                              input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
        mult_valid  = 1'b1;
        mult_func   = func;
        mult_mcand  = a;
        mult_mplier = b;
        mult_tag    = tag;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        clear_inputs();
        #1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        clear_inputs();
        alu_valid  = 3'b111;
        mult_valid = 1'b1;
        #2;
        vectors++; if (cdb_valid !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_cdb_valid: got %b want 00", cdb_valid); end
        vectors++; if (alu_ready !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_alu_ready: got %b want 000", alu_ready); end
        vectors++; if (mult_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mult_ready: got %b want 0", mult_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        @(posedge clock);
        @(posedge clock);
        #1;
        vectors++; if (busy !== 1'b0 || cdb_valid !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_held: busy %b cdb_valid %b want 0 00", busy, cdb_valid); end
        clear_inputs();
        reset = 1'b1;
        #1;
        vectors++; if (alu_ready !== 3'b111) begin miscompares++; $display("[TB] FAIL release_alu_ready: got %b want 111", alu_ready); end
        vectors++; if (mult_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL release_mult_ready: got %b want 1", mult_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL release_busy: got %b want 0", busy); end
        tick();
    endtask

    task automatic test_alu_add;
        do_reset();
        drive_alu(0, F_ADD, 32'd5, 32'd7, 6'd3);
        tick();
        clear_inputs();
        #1;
        vectors++; if (cdb_valid !== 2'b01) begin miscompares++; $display("[TB] FAIL add_valid: got %b want 01", cdb_valid); end
        vectors++; if (port_tag(0) !== 6'd3) begin miscompares++; $display("[TB] FAIL add_tag: got %0d want 3", port_tag(0)); end
        vectors++; if (port_value(0) !== 32'd12) begin miscompares++; $display("[TB] FAIL add_value: got %0d want 12", port_value(0)); end
        vectors++; if (alu_ready !== 3'b111) begin miscompares++; $display("[TB] FAIL add_ready_drain: got %b want 111", alu_ready); end
        tick();
        vectors++; if (cdb_valid !== 2'b00 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL add_after: cdb_valid %b busy %b want 00 0", cdb_valid, busy); end
    endtask

    task automatic test_alu_ops;
        do_reset();
        drive_alu(0, F_SUB, 32'd5, 32'd7, 6'd1);
        drive_alu(1, F_XOR, 32'hF0F0F0F0, 32'h0FF00FF0, 6'd2);
        drive_alu(2, F_SRA, 32'h80000000, 32'd4, 6'd4);
        tick();
        clear_inputs();
        #1;
        vectors++; if (cdb_valid !== 2'b11) begin miscompares++; $display("[TB] FAIL ops_c1_valid: got %b want 11", cdb_valid); end
        vectors++; if (port_tag(0) !== 6'd1 || port_value(0) !== 32'hFFFFFFFE) begin miscompares++; $display("[TB] FAIL ops_sub: tag %0d value %h want 1 fffffffe", port_tag(0), port_value(0)); end
        vectors++; if (port_tag(1) !== 6'd2 || port_value(1) !== 32'hFF00FF00) begin miscompares++; $display("[TB] FAIL ops_xor: tag %0d value %h want 2 ff00ff00", port_tag(1), port_value(1)); end
        vectors++; if (alu_ready !== 3'b011) begin miscompares++; $display("[TB] FAIL ops_ready: got %b want 011", alu_ready); end
        tick();
        vectors++; if (cdb_valid !== 2'b01) begin miscompares++; $display("[TB] FAIL ops_c2_valid: got %b want 01", cdb_valid); end
        vectors++; if (port_tag(0) !== 6'd4 || port_value(0) !== 32'hF8000000) begin miscompares++; $display("[TB] FAIL ops_sra: tag %0d value %h want 4 f8000000", port_tag(0), port_value(0)); end
        tick();
    endtask

    task automatic test_mult;
        logic [1:0]        fn  [4];
        logic [XLEN-1:0]   opa [4];
        logic [XLEN-1:0]   opb [4];
        logic [XLEN-1:0]   exp [4];
        bit                early;
        do_reset();
        drive_mult(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd9);
        tick();
        clear_inputs();
        early = 1'b0;
        for (int c = 1; c < MULT_STAGES; c++) begin
            #1;
            if (cdb_valid !== 2'b00) early = 1'b1;
            tick();
        end
        vectors++; if (early) begin miscompares++; $display("[TB] FAIL mulhu_early: result appeared early, got 1 want 0"); end
        #1;
        vectors++; if (cdb_valid !== 2'b01 || port_tag(0) !== 6'd9) begin miscompares++; $display("[TB] FAIL mulhu_valid: valid %b tag %0d want 01 9", cdb_valid, port_tag(0)); end
        vectors++; if (port_value(0) !== 32'hFFFFFFFE) begin miscompares++; $display("[TB] FAIL mulhu_value: got %h want fffffffe", port_value(0)); end
        tick();
        fn[0] = 2'b00; opa[0] = 32'hFFFFFFFF; opb[0] = 32'hFFFFFFFF; exp[0] = 32'h00000001;
        fn[1] = 2'b01; opa[1] = 32'hFFFFFFFF; opb[1] = 32'hFFFFFFFF; exp[1] = 32'h00000000;
        fn[2] = 2'b10; opa[2] = 32'hFFFFFFFF; opb[2] = 32'hFFFFFFFF; exp[2] = 32'hFFFFFFFF;
        fn[3] = 2'b11; opa[3] = 32'h00010000; opb[3] = 32'h00010000; exp[3] = 32'h00000001;
        for (int c = 0; c < 9; c++) begin
            if (c < 4) drive_mult(fn[c], opa[c], opb[c], TAG_W'(10 + c));
            else mult_valid = 1'b0;
            #1;
            vectors++; if (mult_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL mult_pipe_ready c%0d: got %b want 1", c, mult_ready); end
            if (c >= 4 && c < 8) begin
                vectors++;
                if (cdb_valid !== 2'b01 || port_tag(0) !== TAG_W'(10 + c - 4) || port_value(0) !== exp[c-4]) begin
                    miscompares++;
                    $display("[TB] FAIL mult_pipe_out c%0d: valid %b tag %0d value %h want 01 %0d %h", c, cdb_valid, port_tag(0), port_value(0), 10 + c - 4, exp[c-4]);
                end
            end else begin
                vectors++; if (cdb_valid !== 2'b00) begin miscompares++; $display("[TB] FAIL mult_pipe_idle c%0d: got %b want 00", c, cdb_valid); end
            end
            tick();
        end
    endtask

    task automatic test_collision;
        do_reset();
        drive_mult(2'b00, 32'd3, 32'd5, 6'd23);
        tick();
        clear_inputs();
        tick();
        tick();
        drive_alu(0, F_ADD, 32'd1, 32'd2, 6'd20);
        drive_alu(1, F_AND, 32'hFF00FF00, 32'h0FF00FF0, 6'd21);
        drive_alu(2, F_OR, 32'h12340000, 32'h00005678, 6'd22);
        tick();
        clear_inputs();
        #1;
        vectors++; if (cdb_valid !== 2'b11) begin miscompares++; $display("[TB] FAIL coll_c1_valid: got %b want 11", cdb_valid); end
        vectors++; if (port_tag(0) !== 6'd20 || port_value(0) !== 32'd3) begin miscompares++; $display("[TB] FAIL coll_c1_p0: tag %0d value %h want 20 3", port_tag(0), port_value(0)); end
        vectors++; if (port_tag(1) !== 6'd21 || port_value(1) !== 32'h0F000F00) begin miscompares++; $display("[TB] FAIL coll_c1_p1: tag %0d value %h want 21 0f000f00", port_tag(1), port_value(1)); end
        vectors++; if (alu_ready !== 3'b011 || mult_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL coll_c1_ready: alu %b mult %b want 011 0", alu_ready, mult_ready); end
        tick();
        vectors++; if (cdb_valid !== 2'b11) begin miscompares++; $display("[TB] FAIL coll_c2_valid: got %b want 11", cdb_valid); end
        vectors++; if (port_tag(0) !== 6'd22 || port_value(0) !== 32'h12345678) begin miscompares++; $display("[TB] FAIL coll_c2_p0: tag %0d value %h want 22 12345678", port_tag(0), port_value(0)); end
        vectors++; if (port_tag(1) !== 6'd23 || port_value(1) !== 32'd15) begin miscompares++; $display("[TB] FAIL coll_c2_p1: tag %0d value %h want 23 f", port_tag(1), port_value(1)); end
        vectors++; if (alu_ready !== 3'b111 || mult_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL coll_c2_ready: alu %b mult %b want 111 1", alu_ready, mult_ready); end
        tick();
        vectors++; if (cdb_valid !== 2'b00 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL coll_c3_idle: cdb_valid %b busy %b want 00 0", cdb_valid, busy); end
    endtask

    task automatic test_mult_stall;
        logic [TAG_W-1:0] exp_tag [$];
        logic [XLEN-1:0]  exp_val [$];
        logic [TAG_W-1:0] t;
        int               m_issued;
        int               alu_fired;
        int               alu_seen;
        bit               stall_seen;
        do_reset();
        m_issued   = 0;
        alu_fired  = 0;
        alu_seen   = 0;
        stall_seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            alu_valid = '0;
            if (c < 30) begin
                for (int l = 0; l < NUM_ALU; l++)
                    drive_alu(l, F_ADD, XLEN'(c), XLEN'(l), TAG_W'(l + 1));
            end
            if (m_issued < 8) drive_mult(2'b00, XLEN'(m_issued + 3), XLEN'(m_issued + 4), TAG_W'(32 + m_issued));
            else mult_valid = 1'b0;
            #1;
            for (int k = 0; k < CDB_W; k++) begin
                if (cdb_valid[k]) begin
                    t = port_tag(k);
                    if (t >= 6'd32) begin
                        vectors++;
                        if (exp_tag.size() == 0) begin
                            miscompares++;
                            $display("[TB] FAIL stall_extra: unexpected mult tag %0d, want none", t);
                        end else begin
                            if (t !== exp_tag[0] || port_value(k) !== exp_val[0]) begin
                                miscompares++;
                                $display("[TB] FAIL stall_order: tag %0d value %h want %0d %h", t, port_value(k), exp_tag[0], exp_val[0]);
                            end
                            void'(exp_tag.pop_front());
                            void'(exp_val.pop_front());
                        end
                    end else begin
                        alu_seen++;
                    end
                end
            end
            alu_fired += $countones(alu_valid & alu_ready);
            if (mult_valid && !mult_ready) stall_seen = 1'b1;
            if (mult_valid && mult_ready) begin
                exp_tag.push_back(TAG_W'(32 + m_issued));
                exp_val.push_back(XLEN'((m_issued + 3) * (m_issued + 4)));
                m_issued++;
            end
            if (c >= 30 && m_issued == 8 && !busy) break;
            tick();
        end
        clear_inputs();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_drain_timeout: busy %b want 0", busy); end
        vectors++; if (m_issued != 8) begin miscompares++; $display("[TB] FAIL stall_issued: got %0d want 8", m_issued); end
        vectors++; if (exp_tag.size() != 0) begin miscompares++; $display("[TB] FAIL stall_lost: %0d results missing, want 0", exp_tag.size()); end
        vectors++; if (alu_seen != alu_fired) begin miscompares++; $display("[TB] FAIL stall_alu_count: delivered %0d want %0d", alu_seen, alu_fired); end
        vectors++; if (!stall_seen) begin miscompares++; $display("[TB] FAIL stall_seen: got 0 want 1"); end
        tick();
    endtask

    task automatic test_flush;
        bit leaked;
        do_reset();
        drive_mult(2'b00, 32'd2, 32'd3, 6'd50);
        tick();
        drive_mult(2'b00, 32'd4, 32'd5, 6'd51);
        tick();
        drive_mult(2'b00, 32'd6, 32'd7, 6'd52);
        drive_alu(0, F_ADD, 32'd1, 32'd1, 6'd53);
        drive_alu(1, F_ADD, 32'd2, 32'd2, 6'd54);
        tick();
        clear_inputs();
        flush = 1'b1;
        #1;
        vectors++; if (cdb_valid !== 2'b00) begin miscompares++; $display("[TB] FAIL flush_cdb: got %b want 00", cdb_valid); end
        vectors++; if (alu_ready !== 3'b000 || mult_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_ready: alu %b mult %b want 000 0", alu_ready, mult_ready); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_busy_before: got %b want 1", busy); end
        tick();
        flush = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_busy_after: got %b want 0", busy); end
        vectors++; if (alu_ready !== 3'b111 || mult_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_ready_after: alu %b mult %b want 111 1", alu_ready, mult_ready); end
        leaked = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (cdb_valid !== 2'b00) leaked = 1'b1;
            tick();
        end
        vectors++; if (leaked) begin miscompares++; $display("[TB] FAIL flush_leak: result after flush, got 1 want 0"); end
        drive_alu(2, F_ADD, 32'd10, 32'd20, 6'd60);
        drive_mult(2'b00, 32'd6, 32'd7, 6'd61);
        tick();
        clear_inputs();
        #1;
        vectors++; if (cdb_valid !== 2'b01 || port_tag(0) !== 6'd60 || port_value(0) !== 32'd30) begin miscompares++; $display("[TB] FAIL flush_new_alu: valid %b tag %0d value %0d want 01 60 30", cdb_valid, port_tag(0), port_value(0)); end
        tick();
        tick();
        tick();
        vectors++; if (cdb_valid !== 2'b01 || port_tag(0) !== 6'd61 || port_value(0) !== 32'd42) begin miscompares++; $display("[TB] FAIL flush_new_mult: valid %b tag %0d value %0d want 01 61 42", cdb_valid, port_tag(0), port_value(0)); end
        tick();
    endtask

    task automatic test_reset_mid;
        bit leaked;
        do_reset();
        drive_alu(0, F_ADD, 32'd1, 32'd2, 6'd5);
        drive_mult(2'b00, 32'd2, 32'd2, 6'd6);
        tick();
        clear_inputs();
        reset = 1'b0;
        #1;
        vectors++; if (cdb_valid !== 2'b00 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_clear: cdb_valid %b busy %b want 00 0", cdb_valid, busy); end
        vectors++; if (alu_ready !== 3'b000 || mult_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_ready: alu %b mult %b want 000 0", alu_ready, mult_ready); end
        tick();
        reset = 1'b1;
        leaked = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (cdb_valid !== 2'b00 || busy !== 1'b0) leaked = 1'b1;
            tick();
        end
        vectors++; if (leaked) begin miscompares++; $display("[TB] FAIL midreset_leak: activity after reset, got 1 want 0"); end
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_alu_add();
        test_alu_ops();
        test_mult();
        test_collision();
        test_mult_stall();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
